// File: rtl/muldiv_sequencer_pkg.sv
// Shared op codes, FSM state type and controller decode helpers for the
// multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_MULU = 4'd11;
  localparam logic [3:0] ALU_DIV  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } md_state_t;

  function automatic logic mdIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic mdIsSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Lets the controller turn its alu_control code into the sequencer op.
  function automatic logic [1:0] aluToMdOp(input logic [3:0] aluCtl);
    logic [1:0] op;
    op = MD_MULT;
    case (aluCtl)
      ALU_MUL:  op = MD_MULT;
      ALU_MULU: op = MD_MULTU;
      ALU_DIV:  op = MD_DIV;
      ALU_DIVU: op = MD_DIVU;
      default:  op = MD_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decode-side handshake and HI/LO result bundle between the controller
// (master) and the multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             hilo_rd;

  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush, hilo_rd,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, hilo_rd,
    output busy, stall, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the unsigned multiply (add then shift right) or
// restoring divide (shift left then trial subtract) on {accHi, accLo}.
module muldiv_sequencer_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_isDiv,
  input  logic [WIDTH-1:0] i_accHi,
  input  logic [WIDTH-1:0] i_accLo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_accHi,
  output logic [WIDTH-1:0] o_accLo
);

  logic [WIDTH:0] w_mulSum;
  logic [WIDTH:0] w_divRem;
  logic [WIDTH:0] w_divDiff;

  // Bit WIDTH of the trial difference is the borrow: set means the divisor
  // did not fit and the shifted remainder is kept.
  always_comb begin
    w_mulSum  = i_accLo[0] ? ({1'b0, i_accHi} + {1'b0, i_operand}) : {1'b0, i_accHi};
    w_divRem  = {i_accHi, i_accLo[WIDTH-1]};
    w_divDiff = w_divRem - {1'b0, i_operand};

    if (i_isDiv) begin
      if (!w_divDiff[WIDTH]) begin
        o_accHi = w_divDiff[WIDTH-1:0];
        o_accLo = {i_accLo[WIDTH-2:0], 1'b1};
      end else begin
        o_accHi = w_divRem[WIDTH-1:0];
        o_accLo = {i_accLo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_accHi = w_mulSum[WIDTH:1];
      o_accLo = {w_mulSum[0], i_accLo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: works on magnitudes one bit per
// cycle, fixes signs at the end and commits HI/LO only when entering DONE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  md_state_t r_state;
  md_state_t w_nextState;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_signed;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_accHi;
  logic [WIDTH-1:0] r_accLo;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_negLo;
  logic             r_negHi;
  logic             r_dbz;

  logic               w_isDiv;
  logic               w_divZero;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH-1:0]   w_stepHi;
  logic [WIDTH-1:0]   w_stepLo;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;
  logic [2*WIDTH-1:0] w_prod;

  muldiv_sequencer_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_isDiv  (w_isDiv),
    .i_accHi  (r_accHi),
    .i_accLo  (r_accLo),
    .i_operand(r_operand),
    .o_accHi  (w_stepHi),
    .o_accLo  (w_stepLo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // flush beats start in IDLE and aborts PREP/RUN/FIX, but DONE always commits.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.flush) begin
          w_nextState = IDLE;
        end else if (bus.start) begin
          w_nextState = PREP;
        end
      end
      PREP: begin
        if (bus.flush) begin
          w_nextState = IDLE;
        end else if (w_divZero) begin
          w_nextState = DONE;
        end else begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          w_nextState = IDLE;
        end else if (r_cnt == '0) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        if (bus.flush) begin
          w_nextState = IDLE;
        end else begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state != IDLE);
    bus.stall       = (r_state != IDLE) && (bus.hilo_rd || bus.start);
    bus.done        = (r_state == DONE);
    bus.div_by_zero = (r_state == DONE) && r_dbz;
    bus.hi          = r_hi;
    bus.lo          = r_lo;
  end

  // Multiply negates the full double-width product; divide negates quotient
  // and remainder independently (remainder follows the dividend's sign).
  always_comb begin
    w_isDiv   = mdIsDiv(r_op);
    w_divZero = w_isDiv && (r_b == '0);
    w_absA    = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    w_absB    = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    w_prod    = r_negLo ? -{r_accHi, r_accLo} : {r_accHi, r_accLo};
    w_fixHi   = w_prod[2*WIDTH-1:WIDTH];
    w_fixLo   = w_prod[WIDTH-1:0];
    if (w_isDiv) begin
      w_fixHi = r_negHi ? -r_accHi : r_accHi;
      w_fixLo = r_negLo ? -r_accLo : r_accLo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= MD_MULT;
      r_signed  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_operand <= '0;
      r_negLo   <= 1'b0;
      r_negHi   <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_nextState == PREP) begin
            r_op     <= bus.op;
            r_signed <= mdIsSigned(bus.op);
            r_a      <= bus.rs_val;
            r_b      <= bus.rt_val;
          end
        end
        PREP: begin
          r_accHi   <= '0;
          r_accLo   <= w_absA;
          r_operand <= w_absB;
          r_cnt     <= CNT_W'(WIDTH - 1);
          r_negLo   <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_negHi   <= r_signed && r_a[WIDTH-1];
          r_dbz     <= w_divZero;
        end
        RUN: begin
          r_accHi <= w_stepHi;
          r_accLo <= w_stepLo;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase

      // HI/LO are visible during the DONE cycle itself, alongside the done pulse.
      if (w_nextState == DONE) begin
        if (r_state == PREP) begin
          r_hi <= r_a;
          r_lo <= '1;
        end else begin
          r_hi <= w_fixHi;
          r_lo <= w_fixLo;
        end
      end
    end
  end

endmodule
